// File: rtl/jk_pkg.sv
// Shared definitions for the JK excitation driver and its helpers.
package jk_pkg;

  // Sequencer states: accept a request, strobe the bank, let it settle, verify.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_CHECK = 2'd3
  } jk_state_e;

  // How excitation don't-cares are resolved (JK table has one X per row).
  localparam int JK_DC_ZERO = 0;
  localparam int JK_DC_ONE  = 1;

endpackage : jk_pkg

// File: rtl/jk_excite.sv
// Combinational JK excitation: from present state s and desired next state t,
// produce per-bit J/K that move a master-slave JK flop from s to t.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int DC_MODE = JK_DC_ZERO
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  if (DC_MODE == JK_DC_ONE) begin : g_dc_one
    // Don't-cares driven 1: set/reset become toggles where the bit flips.
    assign j = t | s;
    assign k = ~(t & s);
  end else begin : g_dc_zero
    // Don't-cares driven 0: only the bits that actually change are excited.
    assign j = t & ~s;
    assign k = ~t & s;
  end

endmodule : jk_excite

// File: rtl/jk_excitation_driver.sv
// Sequences one JK bank update per request: latch target, strobe the bank
// with excitation derived from the shadow state, wait HOLD cycles, then
// compare the bank output to the target and resynchronise the shadow.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int HOLD    = 1,
  parameter int DC_MODE = JK_DC_ZERO
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  input  logic             req_count,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_en,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] shadow
);

  localparam int CW = $clog2(HOLD + 1);

  jk_state_e        state_q, state_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] j_q, k_q;
  logic             jk_en_q, done_q, mismatch_q;

  logic [WIDTH-1:0] tgt_sel;
  logic [WIDTH-1:0] exc_j, exc_k;
  logic             accept, enter_check;

  // Incoming target: either the explicit value or the shadow incremented.
  assign tgt_sel     = req_count ? shadow_q + WIDTH'(1) : req_target;
  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign enter_check = (state_q == ST_HOLD) && (hold_cnt_q == '0);

  // Excitation is derived from the shadow, never from q_fb, so a bank that
  // glitches mid-cycle cannot corrupt the J/K pattern being applied.
  jk_excite #(
    .WIDTH  (WIDTH),
    .DC_MODE(DC_MODE)
  ) u_excite (
    .s(shadow_q),
    .t(tgt_sel),
    .j(exc_j),
    .k(exc_k)
  );

  // State and hold-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the reset branch is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next-state logic: DRIVE and CHECK are single cycles, HOLD counts down.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_DRIVE;
      ST_DRIVE: begin
        state_d    = ST_HOLD;
        hold_cnt_d = CW'(HOLD - 1);
      end
      ST_HOLD: begin
        if (hold_cnt_q == '0) state_d = ST_CHECK;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      ST_CHECK: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered datapath: J/K change only on entry to DRIVE and to CHECK.
  // q_fb is sampled once, on the edge into CHECK, and that single sample
  // feeds both the mismatch flag and the resynchronised shadow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q   <= '0;
      shadow_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
      jk_en_q    <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      jk_en_q    <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      if (accept) begin
        target_q <= tgt_sel;
        j_q      <= exc_j;
        k_q      <= exc_k;
        jk_en_q  <= 1'b1;
      end else if (enter_check) begin
        j_q        <= '0;
        k_q        <= '0;
        done_q     <= 1'b1;
        mismatch_q <= (q_fb != target_q);
        shadow_q   <= q_fb;
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign jk_en     = jk_en_q;
  assign done      = done_q;
  assign mismatch  = mismatch_q;
  assign shadow    = shadow_q;

endmodule : jk_excitation_driver

// File: tb/tb_jk_excitation_driver.sv
// Bench for jk_excitation_driver: a behavioural JK bank closes the loop,
// and a value-level model predicts excitation, bank result and shadow.
module tb_jk_excitation_driver;

  localparam int W    = 4;
  localparam int HOLD = 1;

  logic         clk = 1'b0;
  logic         rst;
  always #5 clk = ~clk;

  // Instance under DC_MODE=0
  logic         req_valid, req_count, req_ready, jk_en, busy, done, mismatch;
  logic [W-1:0] req_target, q_fb, j, k, shadow;
  logic [W-1:0] bank_q, fb_mask;

  // Instance under DC_MODE=1
  logic         d1_valid, d1_count, d1_ready, d1_jk_en, d1_busy, d1_done, d1_mismatch;
  logic [W-1:0] d1_target, d1_q_fb, d1_j, d1_k, d1_shadow;
  logic [W-1:0] d1_bank_q;

  jk_excitation_driver #(.WIDTH(W), .HOLD(HOLD), .DC_MODE(0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_count(req_count), .q_fb(q_fb),
    .j(j), .k(k), .jk_en(jk_en), .busy(busy), .done(done),
    .mismatch(mismatch), .shadow(shadow)
  );

  jk_excitation_driver #(.WIDTH(W), .HOLD(HOLD), .DC_MODE(1)) dut_dc1 (
    .clk(clk), .rst(rst), .req_valid(d1_valid), .req_ready(d1_ready),
    .req_target(d1_target), .req_count(d1_count), .q_fb(d1_q_fb),
    .j(d1_j), .k(d1_k), .jk_en(d1_jk_en), .busy(d1_busy), .done(d1_done),
    .mismatch(d1_mismatch), .shadow(d1_shadow)
  );

  // Behavioural JK banks: capture on jk_en, Q+ = J~Q | ~K Q. fb_mask injects
  // bank faults into the feedback path.
  always @(posedge clk or posedge rst) begin
    if (rst) bank_q <= '0;
    else if (jk_en) bank_q <= (j & ~bank_q) | (~k & bank_q);
  end
  assign q_fb = bank_q ^ fb_mask;

  always @(posedge clk or posedge rst) begin
    if (rst) d1_bank_q <= '0;
    else if (d1_jk_en) d1_bank_q <= (d1_j & ~d1_bank_q) | (~d1_k & d1_bank_q);
  end
  assign d1_q_fb = d1_bank_q;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: believed shadow and actual bank contents.
  logic [W-1:0] m_shadow, m_bank;

  // One full request on the DC_MODE=0 instance, checked cycle by cycle.
  task automatic run_req(input logic [W-1:0] tgt, input logic cnt,
                         input logic keep, input string tag);
    logic [W-1:0] t, ej, ek, diff, efb;
    total_cnt++;
    if ({req_ready, busy, jk_en, done} !== 4'b1000)
      $display("FAIL %s idle: got %b want 1000", tag, {req_ready, busy, jk_en, done});
    else pass_cnt++;
    t  = cnt ? W'(m_shadow + 1) : tgt;
    ej = t & ~m_shadow;
    ek = ~t & m_shadow;
    req_valid = 1'b1; req_target = tgt; req_count = cnt;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0;
    total_cnt++;
    if ({jk_en, busy, req_ready, done, j, k} !== {4'b1100, ej, ek})
      $display("FAIL %s drive: got en/busy/rdy/done=%b j=%b k=%b want 1100 j=%b k=%b",
               tag, {jk_en, busy, req_ready, done}, j, k, ej, ek);
    else pass_cnt++;
    repeat (HOLD) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({jk_en, busy, req_ready, done, j, k} !== {4'b0100, ej, ek})
        $display("FAIL %s hold: got en/busy/rdy/done=%b j=%b k=%b want 0100 j=%b k=%b",
                 tag, {jk_en, busy, req_ready, done}, j, k, ej, ek);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    // Bits where shadow and target agree get J=K=0 and keep the real bank
    // value; differing bits are forced to the target value.
    diff   = m_shadow ^ t;
    m_bank = (m_bank & ~diff) | (t & diff);
    efb    = m_bank ^ fb_mask;
    total_cnt++;
    if ({done, mismatch, jk_en, busy, j, k, shadow} !==
        {1'b1, (efb != t), 1'b0, 1'b1, 8'h00, efb})
      $display("FAIL %s check: got done/mm/en/busy=%b j=%b k=%b shadow=%b want %b j=0000 k=0000 shadow=%b",
               tag, {done, mismatch, jk_en, busy}, j, k, shadow,
               {1'b1, (efb != t), 2'b01}, efb);
    else pass_cnt++;
    m_shadow = efb;
    @(posedge clk); #1;
    total_cnt++;
    if ({done, mismatch, req_ready, busy} !== 4'b0010)
      $display("FAIL %s return: got done/mm/rdy/busy=%b want 0010", tag,
               {done, mismatch, req_ready, busy});
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; fb_mask = '0;
    req_valid = 1'b1; req_target = 4'hF; req_count = 1'b0;
    d1_valid = 1'b0; d1_target = '0; d1_count = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({req_ready, busy, jk_en, done, mismatch, j, k, shadow} !== {5'b10000, 12'h000})
      $display("FAIL reset_values: got %b want 10000_000000000000",
               {req_ready, busy, jk_en, done, mismatch, j, k, shadow});
    else pass_cnt++;
    rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({req_ready, busy, jk_en, d1_ready, d1_busy} !== 5'b10010)
      $display("FAIL reset_no_accept: got %b want 10010",
               {req_ready, busy, jk_en, d1_ready, d1_busy});
    else pass_cnt++;
    m_shadow = '0; m_bank = '0;
  endtask

  task automatic test_directed();
    run_req(4'b1010, 1'b0, 1'b0, "tgt_1010");
    run_req(4'b0110, 1'b0, 1'b0, "tgt_0110");
    run_req(4'b1111, 1'b0, 1'b0, "tgt_1111");
    run_req(4'b0000, 1'b1, 1'b0, "count_wrap");
    run_req(4'b0000, 1'b0, 1'b0, "same_target");
  endtask

  task automatic test_mismatch();
    fb_mask = 4'b0001;
    run_req(4'b0110, 1'b0, 1'b0, "mismatch");
    fb_mask = '0;
    run_req(4'b0000, 1'b1, 1'b0, "count_after_mm");
  endtask

  task automatic test_dc_one();
    logic [W-1:0] s, t;
    logic [W-1:0] tgts [2];
    tgts[0] = 4'b0011; tgts[1] = 4'b0101;
    s = '0;
    for (int i = 0; i < 2; i++) begin
      t = tgts[i];
      d1_valid = 1'b1; d1_target = t; d1_count = 1'b0;
      @(posedge clk); #1;
      d1_valid = 1'b0;
      total_cnt++;
      if ({d1_jk_en, d1_j, d1_k} !== {1'b1, t | s, ~(t & s)})
        $display("FAIL dc1_drive_%0d: got en=%b j=%b k=%b want en=1 j=%b k=%b",
                 i, d1_jk_en, d1_j, d1_k, t | s, ~(t & s));
      else pass_cnt++;
      repeat (HOLD + 1) @(posedge clk);
      #1;
      total_cnt++;
      if ({d1_done, d1_mismatch, d1_shadow} !== {2'b10, t})
        $display("FAIL dc1_check_%0d: got done=%b mm=%b shadow=%b want done=1 mm=0 shadow=%b",
                 i, d1_done, d1_mismatch, d1_shadow, t);
      else pass_cnt++;
      @(posedge clk); #1;
      s = t;
    end
  endtask

  task automatic test_back_to_back();
    run_req(4'b1001, 1'b0, 1'b1, "b2b_0");
    run_req(4'b0000, 1'b1, 1'b1, "b2b_1");
    run_req(4'b0011, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    logic [W-1:0] tgt;
    logic         cnt, keep;
    for (int i = 0; i < 24; i++) begin
      tgt  = W'($urandom);
      cnt  = ($urandom_range(0, 3) == 0);
      keep = $urandom_range(0, 1) == 1;
      fb_mask = ($urandom_range(0, 4) == 0) ? W'($urandom_range(1, 15)) : '0;
      run_req(tgt, cnt, keep, $sformatf("rand_%0d", i));
      fb_mask = '0;
    end
    req_valid = 1'b0;
  endtask

  task automatic test_abort();
    req_valid = 1'b1; req_target = ~m_shadow; req_count = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({jk_en, busy} !== 2'b11)
      $display("FAIL abort_drive: got en/busy=%b want 11", {jk_en, busy});
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({jk_en, req_ready, busy} !== 3'b001)
      $display("FAIL abort_no_second_accept: got en/rdy/busy=%b want 001",
               {jk_en, req_ready, busy});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({done, mismatch, jk_en, busy, req_ready, j, k, shadow} !== {5'b00001, 12'h000})
      $display("FAIL abort_immediate: got %b want 00001_000000000000",
               {done, mismatch, jk_en, busy, req_ready, j, k, shadow});
    else pass_cnt++;
    repeat (2) begin
      @(posedge clk); #1;
      total_cnt++;
      if ({done, jk_en, req_ready} !== 3'b001)
        $display("FAIL abort_held: got done/en/rdy=%b want 001", {done, jk_en, req_ready});
      else pass_cnt++;
    end
    rst = 1'b0; req_valid = 1'b0;
    m_shadow = '0; m_bank = '0;
    @(posedge clk); #1;
    total_cnt++;
    if ({req_ready, busy, jk_en, done, shadow} !== 8'b1000_0000)
      $display("FAIL abort_release: got %b want 10000000",
               {req_ready, busy, jk_en, done, shadow});
    else pass_cnt++;
    run_req(4'b0000, 1'b1, 1'b0, "after_abort");
  endtask

  initial begin
    test_reset();
    test_dc_one();
    test_directed();
    test_mismatch();
    test_back_to_back();
    test_random();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_jk_excitation_driver

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Drives the J/K inputs of a WIDTH-bit bank of master-slave JK flip-flops so that the bank reaches a requested value. It works as the initiator for the JK register bank. It accepts a target value, or a count-up request, over a valid/ready handshake. It derives per-bit J/K excitation from a shadow copy of the bank state, strobes the bank once, then checks the bank output against the target. It sits between control logic and any JK-built register or counter in the design.

## Interface
Parameters:
- WIDTH, 4, number of JK flops driven.
- HOLD, 1, cycles J/K stay stable after the strobe before the check (≥1).
- DC_MODE, 0, resolution of excitation don't-cares: 0 = don't-care driven 0; 1 = don't-care driven 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high exactly when FSM is IDLE.
- req_target  in  WIDTH  requested bank value.
- req_count  in  1  1 = ignore req_target and use shadow+1 (mod 2^WIDTH).
- q_fb  in  WIDTH  slave outputs of the JK bank.
- j  out  WIDTH  J inputs to the bank.
- k  out  WIDTH  K inputs to the bank.
- jk_en  out  1  one-cycle capture strobe to the bank.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- mismatch  out  1  one-cycle pulse, coincident with done, when q_fb ≠ target.
- shadow  out  WIDTH  believed bank state.

## Operation
- FSM states:
  - IDLE: req_ready=1. On req_valid&req_ready, latch target (req_count ? shadow+1 : req_target) and go to DRIVE.
  - DRIVE: one cycle. jk_en=1; j/k carry the excitation; go to HOLD.
  - HOLD: HOLD cycles. jk_en=0; j/k held unchanged; go to CHECK.
  - CHECK: one cycle. j=k=0; done=1; mismatch=(q_fb≠target); shadow←q_fb; go to IDLE.
- Excitation per bit, from s=shadow and t=target:
  - DC_MODE=0: j=t&~s, k=~t&s.
  - DC_MODE=1: j=t|s, k=~(t&s).
- Excitation is computed from shadow, never from q_fb. q_fb is sampled only in CHECK.
- When target equals shadow, the full sequence still runs: jk_en still pulses and done still fires.
- Count wrap: shadow all-ones with req_count → target 0.
- req_valid outside IDLE is ignored; nothing is queued.
- Outside DRIVE/HOLD, j and k are 0.
- Reset values: state IDLE, shadow 0, j=k=0, jk_en=0, done=0, mismatch=0, busy=0, req_ready=1.
- Handshakes are not accepted while rst is high.
- rst asserted mid-operation aborts immediately: no done, no mismatch, shadow cleared to 0.

## Timing
- Handshake at cycle n.
- jk_en=1 in cycle n+1.
- HOLD occupies cycles n+2 … n+1+HOLD.
- done/mismatch at cycle n+2+HOLD.
- req_ready returns at cycle n+3+HOLD.
- Request-to-request throughput is HOLD+3 cycles.
- j/k are registered and change only on entry to DRIVE and on entry to CHECK.
- jk_en, done and mismatch are registered outputs; req_ready and busy decode directly from state.

## Structure
- Shared package jk_pkg holds:
  - FSM state enum (IDLE, DRIVE, HOLD, CHECK).
  - DC_MODE constants (JK_DC_ZERO=0, JK_DC_ONE=1).
- Sub-module jk_excite is natural: combinational, parameterised by WIDTH and DC_MODE, inputs s/t, outputs j/k. It is reused by any future JK-based counter generator.
- The HOLD counter width is $clog2(HOLD+1).

## Test plan
All cases use WIDTH=4, HOLD=1, DC_MODE=0 unless stated.
1. Reset, then req_target=1010, q_fb tied to 1010 → j=1010, k=0000, jk_en at n+1, done at n+3, mismatch=0, shadow=1010.
2. shadow=1010, req_target=0110 → j=0100, k=1000, done at n+3, shadow=0110.
3. shadow=1111, req_count=1 → target 0000, j=0000, k=1111, shadow=0000 after CHECK.
4. Target 0110 with q_fb=0111 at CHECK → done=1, mismatch=1, shadow=0111; the next count request targets 1000.
5. DC_MODE=1, shadow=0011, req_target=0101 → j=0111, k=1110.
6. rst pulsed during HOLD, with req_valid held high throughout → no done, jk_en=0, shadow=0, req_ready=1 after release. A second req_valid during DRIVE is never accepted (one jk_en pulse only).
